// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Sequential instruction fetcher. A registered fetch PC addresses a
//   combinational instruction memory. Each fetched {pc, instruction} pair is
//   captured into a 2-entry FIFO that drains through a valid/ready port.
//   A redirect flushes the FIFO and restarts fetch at a new target.
//
// Configuration:
//   IFU_MISALIGN_CHK_EN - when defined, a redirect to a target that is not
//                         word aligned flushes the queue, raises the sticky
//                         misalign flag and parks the unit in HALT until
//                         reset. When undefined, the target's low two bits
//                         are cleared and the misalign port does not exist.
//
// Parameters:
//   WIDTH    - address / instruction width in bits
//   RESET_PC - byte address of the first fetch after reset
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   imem_addr      out  fetch address (straight from the fetch PC register)
//   imem_data      in   instruction word for imem_addr
//   redirect_valid in   restart fetch at redirect_pc
//   redirect_pc    in   new fetch target
//   out_valid      out  queue head is valid
//   out_ready      in   consumer accepts the queue head
//   out_instr      out  instruction at the queue head (0 when empty)
//   out_pc         out  byte address of out_instr (0 when empty)
//   misalign       out  sticky misaligned-target flag (IFU_MISALIGN_CHK_EN)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_data,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_instr,
`ifdef IFU_MISALIGN_CHK_EN
   output logic             misalign,
`endif
   output logic [WIDTH-1:0] out_pc
);

`ifdef IFU_MISALIGN_CHK_EN
   typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_e;
`else
   typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_e;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] fifo_pc_q [2];
   logic [WIDTH-1:0] fifo_pc_d [2];
   logic [WIDTH-1:0] fifo_instr_q [2];
   logic [WIDTH-1:0] fifo_instr_d [2];
`ifdef IFU_MISALIGN_CHK_EN
   logic             misalign_q, misalign_d;
`endif

   logic             pop;
   logic             push;
   logic             redirect_take;
   logic             bad_target;

   always_comb begin
      state_d         = state_q;
      fetch_pc_d      = fetch_pc_q;
      count_d         = count_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      fifo_pc_d       = fifo_pc_q;
      fifo_instr_d    = fifo_instr_q;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_d      = misalign_q;
      // Once halted, redirects are ignored until reset.
      redirect_take   = redirect_valid && (state_q != ST_HALT);
      bad_target      = (redirect_pc[1:0] != 2'b00);
`else
      redirect_take   = redirect_valid;
      bad_target      = 1'b0;
`endif

      pop  = (count_q != 2'd0) && out_ready;
      // A full queue still accepts a new entry when the head leaves this cycle.
      push = (state_q == ST_RUN) && !redirect_valid && ((count_q < 2'd2) || pop);

      if (state_q == ST_BOOT) begin
         state_d = ST_RUN;
      end

      if (redirect_take) begin
         // Flush wins over any concurrent pop; pointers restart at 0.
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
         if (bad_target) begin
            misalign_d = 1'b1;
            state_d    = ST_HALT;
         end else begin
            fetch_pc_d = redirect_pc & ~WIDTH'(3);
         end
`else
         fetch_pc_d = redirect_pc & ~WIDTH'(3);
`endif
      end else begin
         if (push) begin
            fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
            fifo_instr_d[wr_ptr_q] = imem_data;
            wr_ptr_d               = ~wr_ptr_q;
            fetch_pc_d             = fetch_pc_q + WIDTH'(4);
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         fetch_pc_q <= RESET_PC;
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
`ifdef IFU_MISALIGN_CHK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Queue payload is not reset; the output mux hides it while empty.
   always_ff @(posedge clk) begin
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
   end

   assign imem_addr = fetch_pc_q;
   assign out_valid = (count_q != 2'd0);
   assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
   assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : '0;
`ifdef IFU_MISALIGN_CHK_EN
   assign misalign  = misalign_q;
`endif

   logic unused_bad_target;
   assign unused_bad_target = bad_target;

endmodule
